// File: rtl/gray_link_pkg.sv
// rtl/gray_link_pkg.sv - shared types, defaults and gray decode for the gray-coded frame link
package gray_link_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HUNT,
        ST_SHIFT,
        ST_DECODE,
        ST_DONE
    } rx_state_t;

    function automatic logic [DEFAULT_DATA_W-1:0] gray2bin(input logic [DEFAULT_DATA_W-1:0] gray);
        logic [DEFAULT_DATA_W-1:0] bin;
        logic                      run;
        bin = '0;
        run = 1'b0;
        for (int i = DEFAULT_DATA_W - 1; i >= 0; i--) begin
            run    = run ^ gray[i];
            bin[i] = run;
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// rtl/gray2bin_dec.sv - parameterized combinational gray-to-binary decoder
module gray2bin_dec #(
    parameter int W = 8
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic run;

    // Each binary bit is the running XOR of all gray bits from the MSB down.
    always_comb begin
        bin = '0;
        run = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            run    = run ^ gray[i];
            bin[i] = run;
        end
    end

endmodule

// File: rtl/gray_frame_rx.sv
// rtl/gray_frame_rx.sv - serial gray-coded frame receiver with marker hunt and timeout
module gray_frame_rx
    import gray_link_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              a_clk_en,
    input  logic              a_gray_data,
    output logic              en_handshake,
    output logic              b_done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy
);

    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] dec;
    logic [BCNT_W-1:0] bcnt;
    logic [TCNT_W-1:0] tcnt;
    logic              timeout_hit;

    gray2bin_dec #(.W(DATA_W)) u_dec (
        .gray (sr),
        .bin  (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Marker is tested before the timeout so a marker on the last hunt cycle wins.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_REQ;
            ST_REQ:    if (!a_clk_en) state_nxt = ST_HUNT;
            ST_HUNT: begin
                if (a_gray_data) begin
                    state_nxt = ST_SHIFT;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_SHIFT:  if (bcnt == BCNT_W'(DATA_W - 1)) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_DONE;
            ST_DONE:   if (a_clk_en) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr       <= '0;
            bcnt     <= '0;
            tcnt     <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            b_done   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            b_done   <= 1'b0;
            unique case (state)
                ST_REQ: tcnt <= '0;
                ST_HUNT: begin
                    if (a_gray_data) begin
                        bcnt <= '0;
                    end else if (timeout_hit) begin
                        rx_err <= 1'b1;
                        b_done <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    sr <= {sr[DATA_W-2:0], a_gray_data};
                    if (bcnt != BCNT_W'(DATA_W)) bcnt <= bcnt + 1'b1;
                end
                ST_DECODE: begin
                    rx_data  <= dec;
                    rx_valid <= 1'b1;
                    b_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign en_handshake = (state == ST_REQ);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_gray_frame_rx.sv
// tb/tb_gray_frame_rx.sv - directed self-checking bench for gray_frame_rx
module tb_gray_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       a_clk_en;
    logic       a_gray_data;
    logic       en_handshake;
    logic       b_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_overlap = 0;
    int n_done_wide = 0;
    logic prev_done = 1'b0;

    gray_frame_rx #(.DATA_W(8), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .a_clk_en     (a_clk_en),
        .a_gray_data  (a_gray_data),
        .en_handshake (en_handshake),
        .b_done       (b_done),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b_done) n_done++;
        if (rx_valid) n_valid++;
        if (rx_err) n_err++;
        if (rx_valid && rx_err) n_overlap++;
        if (b_done && prev_done) n_done_wide++;
        prev_done = b_done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input int lag);
        a_gray_data = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (lag) tick;
        a_clk_en = 1'b0;
        tick;
    endtask

    task automatic send_frame(input logic [7:0] gray);
        a_gray_data = 1'b1;
        tick;
        for (int i = 7; i >= 0; i--) begin
            a_gray_data = gray[i];
            tick;
        end
        a_gray_data = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a_clk_en = 1'b1; a_gray_data = 1'b0;
        tick; tick;
        checks++; if (en_handshake !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_handshake); end
        checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", b_done); end
        checks++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got valid=%b err=%b expected 0 0", rx_valid, rx_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int v0, d0, e0;
        logic [7:0] g;
        g = 8'h0D;
        v0 = n_valid; d0 = n_done; e0 = n_err;
        a_clk_en = 1'b1; a_gray_data = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        checks++; if (en_handshake !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_req: got en=%b busy=%b expected 1 1", en_handshake, busy); end
        tick; tick;
        checks++; if (en_handshake !== 1'b1) begin errors++; $display("FAIL basic_req_hold: got %b expected 1", en_handshake); end
        a_clk_en = 1'b0; tick;
        checks++; if (en_handshake !== 1'b0) begin errors++; $display("FAIL basic_hunt_en: got %b expected 0", en_handshake); end
        a_gray_data = 1'b1; tick;
        for (int i = 7; i >= 0; i--) begin
            a_gray_data = g[i];
            tick;
        end
        a_gray_data = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0 at marker+8", rx_valid); end
        tick;
        checks++; if (rx_valid !== 1'b1 || b_done !== 1'b1) begin errors++; $display("FAIL basic_pulse: got valid=%b done=%b expected 1 1 at marker+9", rx_valid, b_done); end
        checks++; if (rx_data !== 8'h09) begin errors++; $display("FAIL basic_data: got %h expected 09", rx_data); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", rx_err); end
        tick;
        checks++; if (rx_valid !== 1'b0 || b_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_after: got valid=%b done=%b busy=%b expected 0 0 1", rx_valid, b_done, busy); end
        a_clk_en = 1'b1; tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b expected 0", busy); end
        checks++; if (n_valid - v0 !== 1 || n_done - d0 !== 1 || n_err - e0 !== 0) begin errors++; $display("FAIL basic_counts: got valid=%0d done=%0d err=%0d expected 1 1 0", n_valid - v0, n_done - d0, n_err - e0); end
    endtask

    task automatic test_timeout;
        int v0;
        v0 = n_valid;
        a_clk_en = 1'b1;
        handshake(0);
        repeat (15) tick;
        checks++; if (rx_err !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL timeout_early: got err=%b done=%b expected 0 0 after 15 hunt cycles", rx_err, b_done); end
        tick;
        checks++; if (rx_err !== 1'b1 || b_done !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got err=%b done=%b expected 1 1", rx_err, b_done); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h09) begin errors++; $display("FAIL timeout_data: got %h expected 09", rx_data); end
        tick;
        checks++; if (rx_err !== 1'b0 || b_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_after: got err=%b done=%b busy=%b expected 0 0 1", rx_err, b_done, busy); end
        a_clk_en = 1'b1; tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b expected 0", busy); end
        checks++; if (n_valid !== v0) begin errors++; $display("FAIL timeout_valid_count: got %0d expected %0d", n_valid, v0); end
    endtask

    task automatic test_reset_mid_shift;
        int d0, v0;
        d0 = n_done; v0 = n_valid;
        a_clk_en = 1'b1;
        handshake(1);
        a_gray_data = 1'b1; tick;
        for (int i = 0; i < 4; i++) begin
            a_gray_data = 1'b0;
            tick;
        end
        reset = 1'b1; a_gray_data = 1'b1; tick;
        checks++; if (en_handshake !== 1'b0 || b_done !== 1'b0 || rx_valid !== 1'b0 || rx_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got en=%b done=%b valid=%b err=%b busy=%b expected all 0", en_handshake, b_done, rx_valid, rx_err, busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h expected 00", rx_data); end
        reset = 1'b0; a_gray_data = 1'b0; a_clk_en = 1'b1;
        repeat (4) tick;
        checks++; if (n_done !== d0 || n_valid !== v0) begin errors++; $display("FAIL midreset_no_done: got done=%0d valid=%0d expected %0d %0d", n_done, n_valid, d0, v0); end
        handshake(0);
        send_frame(8'h0D);
        tick;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h09) begin errors++; $display("FAIL midreset_refrm: got valid=%b data=%h expected 1 09", rx_valid, rx_data); end
        a_clk_en = 1'b1; tick;
    endtask

    task automatic test_all_ones;
        int v0;
        v0 = n_valid;
        a_clk_en = 1'b1;
        handshake(0);
        send_frame(8'h80);
        tick;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hFF) begin errors++; $display("FAIL ones_decode: got valid=%b data=%h expected 1 FF", rx_valid, rx_data); end
        a_clk_en = 1'b1; tick;
        handshake(0);
        send_frame(8'h00);
        tick;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin errors++; $display("FAIL zeros_decode: got valid=%b data=%h expected 1 00", rx_valid, rx_data); end
        a_clk_en = 1'b1; tick;
        checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL ones_valid_count: got %0d expected 2", n_valid - v0); end
    endtask

    task automatic test_back_to_back;
        int stuck;
        logic [7:0] g;
        g = 8'h5A;
        a_clk_en = 1'b1;
        handshake(0);
        a_gray_data = 1'b1; tick;
        for (int i = 7; i >= 0; i--) begin
            a_gray_data = g[i];
            start = (i == 4);
            tick;
        end
        start = 1'b0; a_gray_data = 1'b0;
        tick;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h6C) begin errors++; $display("FAIL b2b_decode: got valid=%b data=%h expected 1 6C", rx_valid, rx_data); end
        stuck = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (busy === 1'b1 && en_handshake === 1'b0) stuck++;
        end
        checks++; if (stuck !== 5) begin errors++; $display("FAIL b2b_hold_done: got %0d cycles busy expected 5", stuck); end
        a_clk_en = 1'b1; tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
        tick;
        checks++; if (en_handshake !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_start_dropped: got en=%b busy=%b expected 0 0", en_handshake, busy); end
        start = 1'b1; tick; start = 1'b0;
        checks++; if (en_handshake !== 1'b1) begin errors++; $display("FAIL b2b_second_req: got %b expected 1", en_handshake); end
        a_clk_en = 1'b0; tick;
        send_frame(8'h0D);
        tick;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h09) begin errors++; $display("FAIL b2b_second_frame: got valid=%b data=%h expected 1 09", rx_valid, rx_data); end
        a_clk_en = 1'b1; tick;
    endtask

    task automatic test_trailing;
        int v0;
        a_clk_en = 1'b0; a_gray_data = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        checks++; if (en_handshake !== 1'b1) begin errors++; $display("FAIL early_req: got %b expected 1", en_handshake); end
        tick;
        checks++; if (en_handshake !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL early_req_len: got en=%b busy=%b expected 0 1", en_handshake, busy); end
        v0 = n_valid;
        send_frame(8'h80);
        a_gray_data = 1'b1;
        tick;
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hFF) begin errors++; $display("FAIL trail_decode: got valid=%b data=%h expected 1 FF", rx_valid, rx_data); end
        repeat (12) tick;
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL trail_valid_count: got %0d expected 1", n_valid - v0); end
        checks++; if (rx_data !== 8'hFF || busy !== 1'b1) begin errors++; $display("FAIL trail_hold: got data=%h busy=%b expected FF 1", rx_data, busy); end
        a_clk_en = 1'b1; tick;
        a_gray_data = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trail_idle: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_timeout;
        test_reset_mid_shift;
        test_all_ones;
        test_back_to_back;
        test_trailing;
        tick;
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d expected 0", n_overlap); end
        checks++; if (n_done_wide !== 0) begin errors++; $display("FAIL done_width: got %0d wide cycles expected 0", n_done_wide); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
